// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for the JK modulo counter.
// The master drives the count controls; the slave (the counter) returns its state and flags.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  q, q_bar, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output q, q_bar, tc, wrap
    );
endinterface

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter whose state bits are JK flip-flop cells.
// Per-cell J/K inputs encode the load, toggle and wrap behaviour; wrap is a registered strobe.
module jk_cell (
    input  logic clock,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);
    always_ff @(posedge clock) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign q_bar = ~q;
endmodule

module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic              clock,
    input  logic              rst,
    jk_mod_counter_if.slave   bus
);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] load_clamped;
    logic             tc;
    logic             wrap;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clock (clock),
            .rst   (rst),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

    // Out-of-range load values clamp to the top count; a down-wrap reuses the same J/K pattern.
    always_comb begin
        t_up         = '0;
        t_dn         = '0;
        j            = '0;
        k            = '0;
        load_clamped = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : MAX_VAL;

        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & q[i-1];
            t_dn[i] = t_dn[i-1] & q_bar[i-1];
        end

        if (bus.load) begin
            j = load_clamped;
            k = ~load_clamped;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (q >= MAX_VAL) begin
                    j = '0;
                    k = '1;
                end else begin
                    j = t_up;
                    k = t_up;
                end
            end else begin
                if (q == '0 || q > MAX_VAL) begin
                    j = MAX_VAL;
                    k = ~MAX_VAL;
                end else begin
                    j = t_dn;
                    k = t_dn;
                end
            end
        end
    end

    assign tc = bus.en & ~bus.load & ~rst &
                ((bus.up_dn & (q == MAX_VAL)) | (~bus.up_dn & (q == '0)));

    always_ff @(posedge clock) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end

    assign bus.q     = q;
    assign bus.q_bar = q_bar;
    assign bus.tc    = tc;
    assign bus.wrap  = wrap;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MODULUS=10) with hand-derived expectations.
module tb_jk_mod_counter;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   exp_q;
    logic exp_tc;
    logic prev_tc;

    jk_mod_counter_if #(.WIDTH(4)) bus ();

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input int q_exp, input logic wrap_exp);
        check({tag, "_q"}, 32'(bus.q), 32'(q_exp));
        check({tag, "_qbar"}, 32'(bus.q_bar), 32'((~q_exp) & 4'hF));
        check({tag, "_wrap"}, 32'(bus.wrap), 32'(wrap_exp));
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.up_dn    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;

        // Reset for two cycles; tc is suppressed by rst even though en=0 anyway.
        tick();
        tick();
        check_state("reset", 0, 1'b0);
        check("reset_tc", 32'(bus.tc), 32'd0);

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_tc", 32'(bus.tc), 32'd0);
            tick();
            check_state("idle", 0, 1'b0);
        end

        // Count up 12 edges across the 9 -> 0 wrap.
        bus.en    = 1'b1;
        bus.up_dn = 1'b1;
        exp_q     = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            exp_tc = (exp_q == 9);
            check("up_tc", 32'(bus.tc), 32'(exp_tc));
            prev_tc = exp_tc;
            tick();
            exp_q = (exp_q == 9) ? 0 : exp_q + 1;
            check_state("up", exp_q, prev_tc);
        end

        // Count down from 2 across the 0 -> 9 wrap.
        bus.up_dn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_tc = (exp_q == 0);
            check("dn_tc", 32'(bus.tc), 32'(exp_tc));
            prev_tc = exp_tc;
            tick();
            exp_q = (exp_q == 0) ? 9 : exp_q - 1;
            check_state("dn", exp_q, prev_tc);
        end
        check("dn_end_q", 32'(bus.q), 32'd8);

        // Load beats counting; out-of-range load clamps to 9 and never raises wrap.
        bus.load     = 1'b1;
        bus.load_val = 4'd6;
        #1;
        check("load_tc", 32'(bus.tc), 32'd0);
        tick();
        check_state("load6", 6, 1'b0);
        bus.load_val = 4'd13;
        bus.up_dn    = 1'b1;
        tick();
        check_state("load13", 9, 1'b0);
        #1;
        check("load_at9_tc", 32'(bus.tc), 32'd0);
        tick();
        check_state("load13_again", 9, 1'b0);

        // Reset wins over a simultaneous load mid-count.
        bus.load_val = 4'd5;
        tick();
        check_state("load5", 5, 1'b0);
        bus.load_val = 4'd3;
        rst          = 1'b1;
        #1;
        check("rst_tc", 32'(bus.tc), 32'd0);
        tick();
        check_state("rst_load", 0, 1'b0);
        rst      = 1'b0;
        bus.load = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_state("resume", i, 1'b0);
        end

        // Alternate direction every cycle around 4.
        bus.load     = 1'b1;
        bus.load_val = 4'd4;
        tick();
        check_state("load4", 4, 1'b0);
        bus.load  = 1'b0;
        exp_q     = 4;
        for (int i = 0; i < 4; i++) begin
            bus.up_dn = (i % 2 == 0);
            tick();
            exp_q = bus.up_dn ? exp_q + 1 : exp_q - 1;
            check_state("toggle", exp_q, 1'b0);
        end

        bus.en = 1'b0;
        #1;
        check("hold_tc", 32'(bus.tc), 32'd0);
        tick();
        check_state("hold", 4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
